ps2_keycode_source: RTL and testbench

- Keyboard-side producer for the top level's keycode/keystrobe consumer interface.
- Deserialises PS/2 device-to-host frames and translates set-2 make codes to 7-bit lowercase ASCII.
- Buffers translated keys in a small FIFO and presents them as keycode = {1'b1, ascii[6:0]}, holding each value until the consumer acknowledges with keystrobe.
- Example encodings: 'w' -> 8'hF7, 's' -> 8'hF3, 'a' -> 8'hE1, 'd' -> 8'hE4.

---
 rtl/ps2_keycode_source_pkg.sv | 8 +
 rtl/ps2_keycode_source_if.sv | 7 +
 rtl/ps2_keycode_source_lut.sv | 61 ++++++
 rtl/ps2_keycode_source.sv | 229 ++++++++++++++++++++++
 tb/tb_ps2_keycode_source.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_keycode_source_pkg.sv
// ps2_pkg: shared receiver states and PS/2 constants for the keycode source
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int KEY_VALID_BIT = 7;
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;
endpackage

// File: rtl/ps2_keycode_source_if.sv
// ps2_keycode_source_if: keycode/keystrobe handshake between key producer and consumer
interface ps2_keycode_source_if;
    logic [7:0] keycode;
    logic       keystrobe;
    modport master (output keycode, input keystrobe);
    modport slave (input keycode, output keystrobe);
endinterface

// File: rtl/ps2_keycode_source_lut.sv
// ps2_scancode_lut: set-2 make code to lowercase ASCII (a-z, 0-9, space, arrows); 0 on miss
module ps2_scancode_lut (
    input  logic [7:0] code,
    input  logic       ext,
    output logic [6:0] ascii
);
    // Extended codes only decode the four arrows onto w/s/a/d
    always_comb begin
        ascii = 7'h00;
        if (ext) begin
            case (code)
                8'h75: ascii = 7'h77;
                8'h72: ascii = 7'h73;
                8'h6B: ascii = 7'h61;
                8'h74: ascii = 7'h64;
                default: ;
            endcase
        end else begin
            case (code)
                8'h1C: ascii = 7'h61;
                8'h32: ascii = 7'h62;
                8'h21: ascii = 7'h63;
                8'h23: ascii = 7'h64;
                8'h24: ascii = 7'h65;
                8'h2B: ascii = 7'h66;
                8'h34: ascii = 7'h67;
                8'h33: ascii = 7'h68;
                8'h43: ascii = 7'h69;
                8'h3B: ascii = 7'h6A;
                8'h42: ascii = 7'h6B;
                8'h4B: ascii = 7'h6C;
                8'h3A: ascii = 7'h6D;
                8'h31: ascii = 7'h6E;
                8'h44: ascii = 7'h6F;
                8'h4D: ascii = 7'h70;
                8'h15: ascii = 7'h71;
                8'h2D: ascii = 7'h72;
                8'h1B: ascii = 7'h73;
                8'h2C: ascii = 7'h74;
                8'h3C: ascii = 7'h75;
                8'h2A: ascii = 7'h76;
                8'h1D: ascii = 7'h77;
                8'h22: ascii = 7'h78;
                8'h35: ascii = 7'h79;
                8'h1A: ascii = 7'h7A;
                8'h45: ascii = 7'h30;
                8'h16: ascii = 7'h31;
                8'h1E: ascii = 7'h32;
                8'h26: ascii = 7'h33;
                8'h25: ascii = 7'h34;
                8'h2E: ascii = 7'h35;
                8'h36: ascii = 7'h36;
                8'h3D: ascii = 7'h37;
                8'h3E: ascii = 7'h38;
                8'h46: ascii = 7'h39;
                8'h29: ascii = 7'h20;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/ps2_keycode_source.sv
// ps2_keycode_source: PS/2 frame receiver, set-2 decoder and key FIFO; define PS2_TYPEMATIC_FILTER_EN to drop auto-repeat makes
module ps2_keycode_source
    import ps2_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    ps2_keycode_source_if.master        kbd,
    output logic                        frame_error,
    output logic                        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [1:0]  c_sync_q, d_sync_q;
    logic        c_hist_q, fall, bit_in;
    rx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        par_q, par_d;
    logic [15:0] wdog_q, wdog_d;
    logic        byte_valid_q, byte_valid_d, rx_err, frame_error_q;
    logic        ext_q, ext_d, brk_q, brk_d, push_q, push_d, same_key;
    logic        is_ext, is_brk;
    logic [6:0]  lut_ascii, push_data_q;
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [6:0]  mem_q [FIFO_DEPTH];
    logic [6:0]  head_d;
    logic [7:0]  keycode_q, keycode_d;
    logic        empty, full, pop, push_ok, overflow_q, overflow_d;

    assign fall        = !c_sync_q[1] && c_hist_q;
    assign bit_in      = d_sync_q[1];
    assign frame_error = frame_error_q;
    assign overflow    = overflow_q;
    assign kbd.keycode = keycode_q;

    // Synchronise the raw PS/2 lines; idle-high reset values avoid a false edge
    always_ff @(posedge clk) begin
        if (reset) begin
            c_sync_q <= 2'b11;
            c_hist_q <= 1'b1;
            d_sync_q <= 2'b11;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2_clk};
            c_hist_q <= c_sync_q[1];
            d_sync_q <= {d_sync_q[0], ps2_data};
        end
    end

    // Receiver next state: start/data/parity/stop on PS/2 falling edges, watchdog aborts stalled frames
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        par_d        = par_q;
        byte_valid_d = 1'b0;
        rx_err       = 1'b0;
        wdog_d       = (fall || state_q == IDLE) ? 16'd0 : wdog_q + 16'd1;
        if (state_q != IDLE && !fall && wdog_q == TIMEOUT) begin
            state_d = IDLE;
            rx_err  = 1'b1;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d = bit_in ? IDLE : DATA;
                    rx_err  = bit_in;
                    cnt_d   = 3'd0;
                end
                DATA: begin
                    shift_d = {bit_in, shift_q[7:1]};
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = bit_in;
                    state_d = STOP;
                end
                STOP: begin
                    state_d      = IDLE;
                    byte_valid_d = bit_in && ^{shift_q, par_q};
                    rx_err       = !(bit_in && ^{shift_q, par_q});
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Receiver registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shift_q       <= 8'h00;
            cnt_q         <= 3'd0;
            par_q         <= 1'b0;
            wdog_q        <= 16'd0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            par_q         <= par_d;
            wdog_q        <= wdog_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= rx_err;
        end
    end

    ps2_scancode_lut u_lut (
        .code  (shift_q),
        .ext   (ext_q),
        .ascii (lut_ascii)
    );

    assign is_ext = shift_q == PS2_EXT;
    assign is_brk = shift_q == PS2_BRK;

    // Prefix tracking and push decision for each received byte
    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        push_d = 1'b0;
        if (byte_valid_q) begin
            if (is_ext) begin
                ext_d = 1'b1;
            end else if (is_brk) begin
                brk_d = 1'b1;
            end else begin
                ext_d  = 1'b0;
                brk_d  = 1'b0;
                push_d = !brk_q && lut_ascii != 7'h00 && !same_key;
            end
        end
    end

    // Decoder registers; the translated key is staged one cycle before the FIFO write
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= 7'h00;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            push_q      <= push_d;
            push_data_q <= lut_ascii;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [7:0] last_code_q, last_code_d;
    logic       last_ext_q, last_ext_d, last_vld_q, last_vld_d;

    assign same_key = last_vld_q && last_code_q == shift_q && last_ext_q == ext_q;

    // Remember the last pushed make; its own break releases it
    always_comb begin
        last_code_d = last_code_q;
        last_ext_d  = last_ext_q;
        last_vld_d  = last_vld_q;
        if (byte_valid_q && !is_ext && !is_brk) begin
            if (brk_q && same_key) begin
                last_vld_d = 1'b0;
            end else if (push_d) begin
                last_code_d = shift_q;
                last_ext_d  = ext_q;
                last_vld_d  = 1'b1;
            end
        end
    end

    // Typematic tracker registers
    always_ff @(posedge clk) begin
        if (reset) begin
            last_code_q <= 8'h00;
            last_ext_q  <= 1'b0;
            last_vld_q  <= 1'b0;
        end else begin
            last_code_q <= last_code_d;
            last_ext_q  <= last_ext_d;
            last_vld_q  <= last_vld_d;
        end
    end
`else
    assign same_key = 1'b0;
`endif

    assign empty   = wr_q == rd_q;
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = kbd.keystrobe && !empty;
    assign push_ok = push_q && (!full || pop);

    // FIFO pointers and the registered head; a push landing in the new head slot bypasses memory
    always_comb begin
        wr_d       = wr_q + PW'(push_ok);
        rd_d       = rd_q + PW'(pop);
        head_d     = (push_ok && rd_d == wr_q) ? push_data_q : mem_q[rd_d[AW-1:0]];
        keycode_d  = 8'h00;
        keycode_d[KEY_VALID_BIT] = wr_d != rd_d;
        keycode_d[6:0] = (wr_d != rd_d) ? head_d : 7'h00;
        overflow_d = overflow_q || (push_q && full && !pop);
    end

    // FIFO control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q       <= '0;
            rd_q       <= '0;
            keycode_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            keycode_q  <= keycode_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= push_data_q;
    end
endmodule

// File: tb/tb_ps2_keycode_source.sv
// tb_ps2_keycode_source: directed PS/2 frame stimulus with inline keycode/error/overflow checks
module tb_ps2_keycode_source;
    localparam int          HALF = 10;
    localparam logic [15:0] TO   = 16'd100;

    logic clk = 1'b0;
    logic reset, ps2_clk, ps2_data, frame_error, overflow;
    int   tests = 0, fails = 0, err_cnt = 0, e0;

    ps2_keycode_source_if kbd ();

    ps2_keycode_source #(.FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .kbd         (kbd),
        .frame_error (frame_error),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_error === 1'b1) err_cnt <= err_cnt + 1;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1;
        kbd.keystrobe = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // leaves ps2_clk low after the falling edge of the last bit sent
    task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i < nbits - 1) begin
                repeat (HALF) @(negedge clk);
                ps2_clk = 1'b1;
            end
        end
    endtask

    task automatic release_clk();
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_key(input logic [7:0] code);
        send_frame(code, 1'b0, 1'b0, 11);
        release_clk();
    endtask

    task automatic strobe();
        kbd.keystrobe = 1'b1;
        @(negedge clk);
        kbd.keystrobe = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL reset_keycode: got %h want 00", kbd.keycode); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        tests++; if (frame_error !== 1'b0) begin fails++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
    endtask

    task automatic test_single();
        e0 = err_cnt;
        send_frame(8'h1D, 1'b0, 1'b0, 11);
        repeat (4) @(negedge clk);
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL single_early: got %h want 00", kbd.keycode); end
        @(negedge clk);
        tests++; if (kbd.keycode !== 8'hF7) begin fails++; $display("FAIL single_latency: got %h want F7", kbd.keycode); end
        release_clk();
        tests++; if (kbd.keycode !== 8'hF7) begin fails++; $display("FAIL single_hold: got %h want F7", kbd.keycode); end
        strobe();
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL single_pop: got %h want 00", kbd.keycode); end
        tests++; if (err_cnt !== e0) begin fails++; $display("FAIL single_no_error: got %0d errors want %0d", err_cnt, e0); end
    endtask

    task automatic test_sequence();
        send_key(8'h1C); send_key(8'hF0); send_key(8'h1C); send_key(8'h23);
        tests++; if (kbd.keycode !== 8'hE1) begin fails++; $display("FAIL seq_head_a: got %h want E1", kbd.keycode); end
        strobe();
        tests++; if (kbd.keycode !== 8'hE4) begin fails++; $display("FAIL seq_head_d: got %h want E4", kbd.keycode); end
        strobe();
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL seq_empty: got %h want 00", kbd.keycode); end
    endtask

    task automatic test_extended();
        send_key(8'hE0); send_key(8'h75);
        tests++; if (kbd.keycode !== 8'hF7) begin fails++; $display("FAIL ext_up: got %h want F7", kbd.keycode); end
        strobe();
        send_key(8'hE0); send_key(8'h6B);
        tests++; if (kbd.keycode !== 8'hE1) begin fails++; $display("FAIL ext_left: got %h want E1", kbd.keycode); end
        strobe();
        send_key(8'hE0); send_key(8'h72);
        tests++; if (kbd.keycode !== 8'hF3) begin fails++; $display("FAIL ext_down: got %h want F3", kbd.keycode); end
        strobe();
        send_key(8'h75);
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL lut_miss: got %h want 00", kbd.keycode); end
    endtask

    task automatic test_errors();
        e0 = err_cnt;
        send_frame(8'h1D, 1'b1, 1'b0, 11);
        release_clk();
        tests++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL parity_err: got %0d errors want %0d", err_cnt, e0 + 1); end
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL parity_keycode: got %h want 00", kbd.keycode); end
        send_frame(8'h1D, 1'b0, 1'b1, 11);
        release_clk();
        tests++; if (err_cnt !== e0 + 2) begin fails++; $display("FAIL stop_err: got %0d errors want %0d", err_cnt, e0 + 2); end
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL stop_keycode: got %h want 00", kbd.keycode); end
        send_key(8'h1D);
        tests++; if (kbd.keycode !== 8'hF7) begin fails++; $display("FAIL recover_after_err: got %h want F7", kbd.keycode); end
        strobe();
    endtask

    task automatic test_overflow();
        do_reset();
        send_key(8'h1C); send_key(8'h32); send_key(8'h21); send_key(8'h23); send_key(8'h24);
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", overflow); end
        tests++; if (kbd.keycode !== 8'hE1) begin fails++; $display("FAIL ovf_head0: got %h want E1", kbd.keycode); end
        strobe();
        tests++; if (kbd.keycode !== 8'hE2) begin fails++; $display("FAIL ovf_head1: got %h want E2", kbd.keycode); end
        strobe();
        tests++; if (kbd.keycode !== 8'hE3) begin fails++; $display("FAIL ovf_head2: got %h want E3", kbd.keycode); end
        strobe();
        tests++; if (kbd.keycode !== 8'hE4) begin fails++; $display("FAIL ovf_head3: got %h want E4", kbd.keycode); end
        strobe();
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL ovf_fifth_lost: got %h want 00", kbd.keycode); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_ovf_cleared: got %b want 0", overflow); end
        send_key(8'h1C); send_key(8'h32); send_key(8'h21); send_key(8'h23);
        send_frame(8'h24, 1'b0, 1'b0, 11);
        repeat (4) @(negedge clk);
        strobe();
        tests++; if (kbd.keycode !== 8'hE2) begin fails++; $display("FAIL b2b_pop_head: got %h want E2", kbd.keycode); end
        release_clk();
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_no_ovf: got %b want 0", overflow); end
        kbd.keystrobe = 1'b1;
        @(negedge clk);
        tests++; if (kbd.keycode !== 8'hE3) begin fails++; $display("FAIL level_pop1: got %h want E3", kbd.keycode); end
        @(negedge clk);
        tests++; if (kbd.keycode !== 8'hE4) begin fails++; $display("FAIL level_pop2: got %h want E4", kbd.keycode); end
        @(negedge clk);
        tests++; if (kbd.keycode !== 8'hE5) begin fails++; $display("FAIL level_pop3: got %h want E5", kbd.keycode); end
        @(negedge clk);
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL level_empty: got %h want 00", kbd.keycode); end
        @(negedge clk);
        kbd.keystrobe = 1'b0;
        @(negedge clk);
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL strobe_when_empty: got %h want 00", kbd.keycode); end
        send_key(8'h1C);
        tests++; if (kbd.keycode !== 8'hE1) begin fails++; $display("FAIL after_empty_strobe: got %h want E1", kbd.keycode); end
        strobe();
    endtask

    task automatic test_typematic();
        logic [7:0] rep_exp;
`ifdef PS2_TYPEMATIC_FILTER_EN
        rep_exp = 8'h00;
`else
        rep_exp = 8'hE1;
`endif
        send_key(8'h1C); send_key(8'h1C);
        tests++; if (kbd.keycode !== 8'hE1) begin fails++; $display("FAIL typ_first: got %h want E1", kbd.keycode); end
        strobe();
        tests++; if (kbd.keycode !== rep_exp) begin fails++; $display("FAIL typ_repeat: got %h want %h", kbd.keycode, rep_exp); end
        strobe();
        send_key(8'hF0); send_key(8'h1C); send_key(8'h1C);
        tests++; if (kbd.keycode !== 8'hE1) begin fails++; $display("FAIL typ_after_break: got %h want E1", kbd.keycode); end
        strobe();
    endtask

    task automatic test_timeout();
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, 5);
        release_clk();
        repeat (int'(TO) + 30) @(negedge clk);
        tests++; if (err_cnt !== e0 + 1) begin fails++; $display("FAIL timeout_err: got %0d errors want %0d", err_cnt, e0 + 1); end
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL timeout_keycode: got %h want 00", kbd.keycode); end
        send_key(8'h1C);
        tests++; if (kbd.keycode !== 8'hE1) begin fails++; $display("FAIL timeout_recover: got %h want E1", kbd.keycode); end
        strobe();
    endtask

    task automatic test_reset_midframe();
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b0, 6);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (int'(TO) + 30) @(negedge clk);
        tests++; if (err_cnt !== e0) begin fails++; $display("FAIL midreset_err: got %0d errors want %0d", err_cnt, e0); end
        tests++; if (kbd.keycode !== 8'h00) begin fails++; $display("FAIL midreset_keycode: got %h want 00", kbd.keycode); end
        send_key(8'h1C);
        tests++; if (kbd.keycode !== 8'hE1) begin fails++; $display("FAIL midreset_recover: got %h want E1", kbd.keycode); end
        strobe();
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_extended();
        test_errors();
        test_overflow();
        test_back_to_back();
        test_typematic();
        test_timeout();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
